seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for the vending machine front panel. It accepts a packed BCD value for DIGITS digits and double-buffers it so updates apply only at frame boundaries, with no tearing. It time-multiplexes the digits onto one shared segment bus with a one-hot digit select and decodes each digit, with optional leading-zero blanking and per-digit blinking. It replaces the single-digit combinational segment decode used by the first-generation machine.

---
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_bcd,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_lzb,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0]     i_blink,
`endif
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic                tc;
  logic                frame_end;

  logic [4*DIGITS-1:0] pend_bcd;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_vld;
  logic [4*DIGITS-1:0] act_bcd;
  logic [DIGITS-1:0]   act_dp;

  logic [3:0]          nib;
  logic                dp_bit;
  logic                zero_run;
  logic                blank;
  logic [6:0]          seg7;
  logic                blink_off;
  logic [7:0]          seg_nx;
  logic [DIGITS-1:0]   an_nx;

  assign tc        = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = tc && (idx == IW'(DIGITS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + 1'b1;
      if (tc)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load coinciding with frame_end bypasses pending straight into active.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      act_bcd  <= '0;
      act_dp   <= '0;
    end else if (frame_end && i_load) begin
      act_bcd  <= i_bcd;
      act_dp   <= i_dp;
      pend_vld <= 1'b0;
    end else if (frame_end && pend_vld) begin
      act_bcd  <= pend_bcd;
      act_dp   <= pend_dp;
      pend_vld <= 1'b0;
    end else if (i_load) begin
      pend_bcd <= i_bcd;
      pend_dp  <= i_dp;
      pend_vld <= 1'b1;
    end
  end

  // Walk from the top digit down so zero_run means "this and all above are 0".
  always_comb begin
    nib      = 4'h0;
    dp_bit   = 1'b0;
    zero_run = 1'b1;
    blank    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_bcd[4*k +: 4] == 4'h0);
      if (IW'(k) == idx) begin
        nib    = act_bcd[4*k +: 4];
        dp_bit = act_dp[k];
        blank  = i_lzb && zero_run && (k != 0);
      end
    end
  end

  always_comb begin
    seg7 = 7'h40;
    case (nib)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase && i_blink[idx];
`else
  assign blink_off = (BLINK_FRAMES < 0);
`endif

  always_comb begin
    an_nx      = '0;
    an_nx[idx] = 1'b1;
    seg_nx     = blink_off ? 8'h00 : {dp_bit, blank ? 7'h00 : seg7};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_seg   <= (ACTIVE_LOW != 0) ? '1 : '0;
      o_an    <= (ACTIVE_LOW != 0) ? '1 : '0;
      o_frame <= 1'b0;
    end else begin
      o_seg   <= (ACTIVE_LOW != 0) ? ~seg_nx : seg_nx;
      o_an    <= (ACTIVE_LOW != 0) ? ~an_nx : an_nx;
      o_frame <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [15:0] bcd = 16'h0;
  logic [3:0]  dp = 4'h0;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink = 4'h0;
`endif
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frm;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       frm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .ACTIVE_LOW(0),
    .BLINK_FRAMES(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_load(load),
    .i_bcd(bcd),
    .i_dp(dp),
    .i_lzb(lzb),
`ifdef SEG_BLINK_EN
    .i_blink(blink),
`endif
    .o_seg(seg),
    .o_an(an),
    .o_frame(frm)
  );

  function automatic logic [7:0] exp_seg(logic [15:0] b, logic [3:0] d,
                                         logic lz, int dg);
    logic [3:0] nib;
    logic [6:0] s;
    nib = b[4*dg +: 4];
    case (nib)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h40;
    endcase
    if (lz && dg != 0 && (b >> (4*dg)) == 16'h0)
      s = 7'h00;
    return {d[dg], s};
  endfunction

  task automatic push_cyc(int n, logic [15:0] b, logic [3:0] d,
                          logic lz, logic [3:0] bm);
    exp_t e;
    int dg;
    dg    = n / 4;
    e.an  = 4'b0001 << dg;
    e.seg = bm[dg] ? 8'h00 : exp_seg(b, d, lz, dg);
    e.frm = (n == 15);
    q.push_back(e);
  endtask

  task automatic push_rst();
    exp_t e;
    e = '0;
    q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty got=none exp=entry");
    end else begin
      e = q.pop_front();
      total++;
      assert (an === e.an) else begin
        bad++;
        $error("FAIL an got=%b exp=%b", an, e.an);
      end
      total++;
      assert (seg === e.seg) else begin
        bad++;
        $error("FAIL seg an=%b got=%h exp=%h", e.an, seg, e.seg);
      end
      total++;
      assert (frm === e.frm) else begin
        bad++;
        $error("FAIL frame an=%b got=%b exp=%b", e.an, frm, e.frm);
      end
    end
  endtask

  // One 16-cycle frame; cur_* is what should be displayed, ld* are loads.
  task automatic frame(logic [15:0] cur_b, logic [3:0] cur_d, logic lz,
                       logic [3:0] bm,
                       int a_at, logic [15:0] a_b, logic [3:0] a_d,
                       int b_at, logic [15:0] b_b, logic [3:0] b_d);
    lzb = lz;
    for (int n = 0; n < 16; n++) begin
      push_cyc(n, cur_b, cur_d, lz, bm);
      if (n == a_at) begin
        load = 1'b1;
        bcd  = a_b;
        dp   = a_d;
      end else if (n == b_at) begin
        load = 1'b1;
        bcd  = b_b;
        dp   = b_d;
      end
      cyc();
      load = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      push_rst();
      cyc();
    end
    rst_n = 1'b1;

    for (int n = 0; n < 9; n++) begin
      push_cyc(n, 16'h0, 4'h0, 1'b0, 4'h0);
      if (n == 5) begin
        load = 1'b1;
        bcd  = 16'h5555;
        dp   = 4'hF;
      end
      cyc();
      load = 1'b0;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_rst();
      cyc();
    end
    rst_n = 1'b1;

    frame(16'h0, 4'h0, 1'b0, 4'h0, 3, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    frame(16'h1234, 4'b0100, 1'b0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h1234, 4'b0100, 1'b0, 4'h0, 7, 16'h0070, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0070, 4'h0, 1'b1, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0070, 4'h0, 1'b0, 4'h0, 2, 16'h00A0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h00A0, 4'h0, 1'b0, 4'h0, 1, 16'h1111, 4'h0, 10, 16'h2222, 4'h0);
    frame(16'h2222, 4'h0, 1'b0, 4'h0, 15, 16'h3333, 4'b1001, -1, 16'h0, 4'h0);
    frame(16'h3333, 4'b1001, 1'b0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

`ifdef SEG_BLINK_EN
    blink = 4'b0001;
    rst_n = 1'b0;
    push_rst();
    cyc();
    rst_n = 1'b1;
    frame(16'h0, 4'h0, 1'b0, 4'h0, 0, 16'h0008, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0008, 4'h0, 1'b0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0008, 4'h0, 1'b0, 4'b0001, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0008, 4'h0, 1'b0, 4'b0001, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0008, 4'h0, 1'b0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    frame(16'h0008, 4'h0, 1'b0, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
